// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - card type package and dealer request/result interface
package card_dealer_pkg;
  typedef struct packed {
    logic [1:0] suit;  // Clubs, Diamonds, Hearts, Spades = 0..3
    logic [3:0] rank;  // Two..Ace = 0..12
  } card_t;
endpackage

interface card_dealer_if;
  logic                                 deal_start;
  logic                                 seed_load;
  logic [15:0]                          seed_value;
  logic                                 deal_busy;
  logic                                 deal_done;
  card_dealer_pkg::card_t [1:0][1:0]    player_cards;
  card_dealer_pkg::card_t [2:0]         flop_card;
  card_dealer_pkg::card_t               turn_card;
  card_dealer_pkg::card_t               river_card;

  modport master (
    output deal_start, seed_load, seed_value,
    input  deal_busy, deal_done, player_cards, flop_card, turn_card, river_card
  );

  modport slave (
    input  deal_start, seed_load, seed_value,
    output deal_busy, deal_done, player_cards, flop_card, turn_card, river_card
  );
endinterface

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - LFSR shuffle-and-deal engine drawing 9 distinct cards by rejection sampling
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 31
) (
  input  logic         clk,
  input  logic         reset,
  card_dealer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_e;

  localparam logic [15:0] POLY      = 16'hB400;
  localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [51:0]     used_q, used_d;
  logic [3:0]      slot_q, slot_d;
  logic [7:0]      tries_q, tries_d;
  logic [8:0][5:0] shadow_q, shadow_d;
  logic [8:0][5:0] pub_q, pub_d;

  logic [5:0] cand;
  logic [5:0] free_idx;
  logic [5:0] pick;
  logic       cand_ok;
  logic       take;

  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
  endfunction

  function automatic card_t to_card(logic [5:0] idx);
    card_t c;
    if (idx >= 6'd39) begin
      c.suit = 2'd3;
      c.rank = 4'(idx - 6'd39);
    end else if (idx >= 6'd26) begin
      c.suit = 2'd2;
      c.rank = 4'(idx - 6'd26);
    end else if (idx >= 6'd13) begin
      c.suit = 2'd1;
      c.rank = 4'(idx - 6'd13);
    end else begin
      c.suit = 2'd0;
      c.rank = 4'(idx);
    end
    return c;
  endfunction

  assign cand    = lfsr_q[5:0];
  assign cand_ok = (cand < 6'd52) && !used_q[cand];

  // Lowest unused index; at most 8 cards are used while drawing, so one always exists.
  always_comb begin
    free_idx = 6'd0;
    for (int i = 51; i >= 0; i--) begin
      if (!used_q[i]) free_idx = 6'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_step(lfsr_q);
    used_d   = used_q;
    slot_d   = slot_q;
    tries_d  = tries_q;
    shadow_d = shadow_q;
    pub_d    = pub_q;
    take     = 1'b0;
    pick     = cand;

    unique case (state_q)
      S_IDLE: begin
        if (bus.seed_load) begin
          lfsr_d = (bus.seed_value == 16'h0000) ? SEED : bus.seed_value;
        end else if (bus.deal_start) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        used_d  = '0;
        slot_d  = '0;
        tries_d = '0;
        state_d = S_DRAW;
      end

      S_DRAW: begin
        if (cand_ok) begin
          take = 1'b1;
        end else if (tries_q == TRY_LIMIT) begin
          take = 1'b1;
          pick = free_idx;
        end else begin
          tries_d = tries_q + 8'd1;
        end

        if (take) begin
          shadow_d[slot_q] = pick;
          used_d[pick]     = 1'b1;
          slot_d           = slot_q + 4'd1;
          tries_d          = '0;
          // Publish on the edge into DONE so cards and deal_done appear together.
          if (slot_q == 4'd8) begin
            state_d = S_DONE;
            pub_d   = shadow_d;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      used_q   <= '0;
      slot_q   <= '0;
      tries_q  <= '0;
      shadow_q <= '0;
      pub_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      used_q   <= used_d;
      slot_q   <= slot_d;
      tries_q  <= tries_d;
      shadow_q <= shadow_d;
      pub_q    <= pub_d;
    end
  end

  assign bus.deal_busy = (state_q != S_IDLE);
  assign bus.deal_done = (state_q == S_DONE);

  assign bus.player_cards[0][0] = to_card(pub_q[0]);
  assign bus.player_cards[1][0] = to_card(pub_q[1]);
  assign bus.player_cards[0][1] = to_card(pub_q[2]);
  assign bus.player_cards[1][1] = to_card(pub_q[3]);
  assign bus.flop_card[0]       = to_card(pub_q[4]);
  assign bus.flop_card[1]       = to_card(pub_q[5]);
  assign bus.flop_card[2]       = to_card(pub_q[6]);
  assign bus.turn_card          = to_card(pub_q[7]);
  assign bus.river_card         = to_card(pub_q[8]);

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer against a cycle-exact deal model
module tb_card_dealer;
  import card_dealer_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int MT0 = 31;
  localparam int MT1 = 1;

  typedef struct packed {
    logic [8:0][5:0] idx;
    int              lat;
    int              fb;
    int              st;
  } deal_t;

  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic            rst_s   = 1'b1;
  int              cyc     = 0;
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [15:0]     m_lfsr0, m_lfsr1;
  deal_t           q0[$];
  deal_t           q1[$];
  int              n_done0 = 0;
  int              n_done1 = 0;
  int              fb1     = 0;
  int              bad_change = 0;
  logic [51:0]     seen0   = '0;
  logic [8:0][5:0] obs0, obs1;
  logic [8:0][5:0] prev0 = '0;
  logic [8:0][5:0] prev1 = '0;

  always #5 clk = ~clk;

  card_dealer_if bus0 ();
  card_dealer_if bus1 ();

  card_dealer #(.SEED(SEED), .MAX_TRIES(MT0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  card_dealer #(.SEED(SEED), .MAX_TRIES(MT1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign obs0 = {bus0.river_card, bus0.turn_card, bus0.flop_card[2], bus0.flop_card[1],
                 bus0.flop_card[0], bus0.player_cards[1][1], bus0.player_cards[0][1],
                 bus0.player_cards[1][0], bus0.player_cards[0][0]};
  assign obs1 = {bus1.river_card, bus1.turn_card, bus1.flop_card[2], bus1.flop_card[1],
                 bus1.flop_card[0], bus1.player_cards[1][1], bus1.player_cards[0][1],
                 bus1.player_cards[1][0], bus1.player_cards[0][0]};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(logic [15:0] l);
    logic [15:0] n;
    n = {1'b0, l[15:1]};
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [5:0] exp_card(int idx);
    logic [1:0] s;
    logic [3:0] r;
    s = 2'(idx / 13);
    r = 4'(idx % 13);
    return {s, r};
  endfunction

  // l0 is the LFSR value during the cycle whose rising edge samples deal_start.
  function automatic deal_t model(logic [15:0] l0, int mt);
    deal_t       d;
    logic [51:0] used;
    logic [15:0] l;
    logic [5:0]  cand, pick;
    int          tries, n;
    bit          got;
    d    = '0;
    used = '0;
    n    = 0;
    l    = step(step(l0));
    for (int s = 0; s < 9; s++) begin
      tries = 0;
      got   = 1'b0;
      pick  = '0;
      while (!got) begin
        cand = l[5:0];
        n++;
        if (cand < 6'd52 && used[cand] == 1'b0) begin
          pick = cand;
          got  = 1'b1;
        end else if (tries == mt) begin
          for (int k = 0; k < 52; k++) begin
            if (!got && !used[k]) begin
              pick = 6'(k);
              got  = 1'b1;
            end
          end
          d.fb++;
        end else begin
          tries++;
        end
        l = step(l);
      end
      used[pick] = 1'b1;
      d.idx[s]   = pick;
    end
    d.lat = n + 2;
    return d;
  endfunction

  task automatic score(input int u, input deal_t d, input logic [8:0][5:0] o);
    logic [51:0] m;
    int          lat, ix, mt;
    m   = '0;
    lat = cyc - d.st;
    mt  = (u == 0) ? MT0 : MT1;
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("u%0d_card%0d", u, i), 32'(o[i]), 32'(exp_card(int'(d.idx[i]))));
      ix = int'(o[i][5:4]) * 13 + int'(o[i][3:0]);
      if (ix < 52) m[ix] = 1'b1;
    end
    check_eq($sformatf("u%0d_latency", u), lat, d.lat);
    check_eq($sformatf("u%0d_lat_bound", u), 32'(lat <= 2 + 9 * (mt + 1)), 32'd1);
    check_eq($sformatf("u%0d_distinct", u), $countones(m), 9);
    if (u == 0) seen0 = seen0 | m;
    else fb1 = fb1 + d.fb;
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
    if (reset) m_lfsr0 <= SEED;
    else if (bus0.seed_load) m_lfsr0 <= (bus0.seed_value == 16'h0) ? SEED : bus0.seed_value;
    else m_lfsr0 <= step(m_lfsr0);
    if (reset) m_lfsr1 <= SEED;
    else if (bus1.seed_load) m_lfsr1 <= (bus1.seed_value == 16'h0) ? SEED : bus1.seed_value;
    else m_lfsr1 <= step(m_lfsr1);
  end

  always @(negedge clk) begin : mon0
    deal_t d;
    if (!rst_s) begin
      if (bus0.deal_done) begin
        n_done0++;
        check_eq("u0_done_expected", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) begin
          d = q0.pop_front();
          score(0, d, obs0);
        end
      end else if (obs0 !== prev0) begin
        bad_change++;
      end
    end
    prev0 = obs0;
  end

  always @(negedge clk) begin : mon1
    deal_t d;
    if (!rst_s) begin
      if (bus1.deal_done) begin
        n_done1++;
        check_eq("u1_done_expected", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) begin
          d = q1.pop_front();
          score(1, d, obs1);
        end
      end else if (obs1 !== prev1) begin
        bad_change++;
      end
    end
    prev1 = obs1;
  end

  task automatic start_deal(input int u);
    int    n;
    deal_t d;
    n = 0;
    @(negedge clk);
    while (((u == 0) ? bus0.deal_busy : bus1.deal_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("u%0d_idle_wait", u), 32'(n < 400), 32'd1);
    d    = model((u == 0) ? m_lfsr0 : m_lfsr1, (u == 0) ? MT0 : MT1);
    d.st = cyc;
    if (u == 0) begin
      q0.push_back(d);
      bus0.deal_start = 1'b1;
    end else begin
      q1.push_back(d);
      bus1.deal_start = 1'b1;
    end
    @(negedge clk);
    bus0.deal_start = 1'b0;
    bus1.deal_start = 1'b0;
  endtask

  task automatic drain(input int u);
    int n;
    n = 0;
    while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("u%0d_drain", u), (u == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    bus0.deal_start = 1'b0; bus0.seed_load = 1'b0; bus0.seed_value = '0;
    bus1.deal_start = 1'b0; bus1.seed_load = 1'b0; bus1.seed_value = '0;
    reset = 1'b1;

    // T1: reset state
    repeat (4) @(negedge clk);
    check_eq("t1_busy", 32'(bus0.deal_busy), 32'd0);
    check_eq("t1_done", 32'(bus0.deal_done), 32'd0);
    check_eq("t1_cards0", 32'(obs0 == '0), 32'd1);
    check_eq("t1_cards1", 32'(obs1 == '0), 32'd1);
    check_eq("t1_lfsr", 32'(dut0.lfsr_q), 32'(SEED));
    reset = 1'b0;

    // T2: seed 1 then deal
    @(negedge clk);
    bus0.seed_value = 16'h0001;
    bus0.seed_load  = 1'b1;
    @(negedge clk);
    bus0.seed_load  = 1'b0;
    check_eq("t2_seed_loaded", 32'(dut0.lfsr_q), 32'h0001);
    start_deal(0);
    check_eq("t2_busy_after_start", 32'(bus0.deal_busy), 32'd1);
    drain(0);

    // T3: zero seed maps to SEED
    @(negedge clk);
    bus0.seed_value = 16'h0000;
    bus0.seed_load  = 1'b1;
    @(negedge clk);
    bus0.seed_load  = 1'b0;
    check_eq("t3_zero_seed", 32'(dut0.lfsr_q), 32'(SEED));
    start_deal(0);
    drain(0);

    // T4: MAX_TRIES=1 build
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_deal(1);
    end
    drain(1);
    check_eq("t4_fallback_used", 32'(fb1 > 0), 32'd1);

    // T5: start while busy is ignored, then reset during DRAW
    start_deal(0);
    repeat (3) @(negedge clk);
    bus0.deal_start = 1'b1;
    @(negedge clk);
    bus0.deal_start = 1'b0;
    drain(0);
    repeat (20) @(negedge clk);
    check_eq("t5_ignored_start", 32'(bus0.deal_busy), 32'd0);
    start_deal(0);
    repeat (4) @(negedge clk);
    check_eq("t5_in_draw", 32'(bus0.deal_busy), 32'd1);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_rst_cards", 32'(obs0 == '0), 32'd1);
    check_eq("t5_rst_busy", 32'(bus0.deal_busy), 32'd0);
    check_eq("t5_rst_done", 32'(bus0.deal_done), 32'd0);
    reset = 1'b0;
    d0 = n_done0;
    start_deal(0);
    drain(0);
    repeat (20) @(negedge clk);
    check_eq("t5_one_done", n_done0 - d0, 1);

    // T6: back-to-back deals with random gaps
    seen0 = '0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_deal(0);
    end
    drain(0);
    check_eq("t6_all_idx_seen", 32'(&seen0), 32'd1);
    check_eq("t6_outputs_stable", bad_change, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
